mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access stage between EX/MEM and MEMWB_Register. Performs loads/stores on an internal
//  word-organised data RAM with programmable wait states, stalls the pipeline while busy,
//  sign/zero-extends load data and drives Load/rf/Data_Mem/Alu inputs of MEMWB_Register.
//  Non-memory instructions pass through in the same cycle with no stall.
// PARAMETERS
//  DEPTH_WORDS  256  RAM depth in 32-bit words (power of 2); ADDR_WIDTH = log2(DEPTH_WORDS)
//  WAIT_CYCLES  2    extra busy cycles per memory op (0..15)
// PORTS
//  CLK            in   1   clock, rising edge
//  CLR            in   1   reset, asynchronous, active-low
//  Load_In        in   1   instruction is a load
//  Store_In       in   1   instruction is a store
//  rf_In          in   1   instruction writes register file
//  Size_In        in   2   00 byte, 01 halfword, 10 word, 11 treated as word
//  Signed_In      in   1   1 = sign-extend byte/half load, 0 = zero-extend
//  Alu_In         in   32  ALU result / effective address
//  Store_Data_In  in   32  store data (low byte/half used for sub-word stores)
//  Load_Out       out  1   to MEMWB Load_In
//  rf_Out         out  1   to MEMWB rf_In
//  Data_Mem_Out   out  32  extended load data, to MEMWB Data_Mem_In
//  Alu_Out        out  32  to MEMWB Alu_In
//  Stall_Out      out  1   1 = hold PC/IF/ID/ID-EX/EX-MEM; inputs must stay stable
//  Misalign_Out   out  1   one-cycle flag: misaligned access suppressed
// BEHAVIOUR
//  - CLR low (any time, incl. mid-op): state=IDLE, counter=0, latched regs=0; all outputs 0.
//    RAM contents not reset; an in-flight store not yet committed is dropped.
//  - FSM IDLE/BUSY/DONE. Mem op = Load_In|Store_In.
//  - IDLE, no mem op: Stall_Out=0, rf_Out=rf_In, Alu_Out=Alu_In, Load_Out=0, Data_Mem_Out=0.
//  - IDLE, mem op: Stall_Out=1 (combinational, same cycle), rf_Out=0, Load_Out=0; latch controls,
//    address, store data. Next: BUSY with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else DONE.
//  - BUSY: Stall_Out=1, bubble outputs (rf_Out=0, Load_Out=0); counter decrements; counter==0 -> DONE.
//  - Entry to DONE edge: load reads RAM into read register; store writes RAM with byte enables.
//  - DONE (1 cycle): Stall_Out=0; Load_Out=latched load, rf_Out=latched rf, Alu_Out=latched addr,
//    Data_Mem_Out=extended read data (0 for stores). Next: IDLE unconditionally.
//  - Mem op occupies WAIT_CYCLES+2 cycles; MEMWB captures DONE outputs on the closing edge.
//  - Word index = addr[ADDR_WIDTH+1:2]; higher address bits ignored (wraps). Little-endian lanes:
//    byte lane addr[1:0]; half lane addr[1]. Byte load -> [7:0] extended; half -> [15:0] extended.
//  - Sub-word store updates only addressed lane(s); other bytes of word unchanged.
//  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): IDLE->DONE directly (no wait),
//    no RAM write, in DONE rf_Out=0, Load_Out=0, Data_Mem_Out=0, Misalign_Out=1 for that cycle only.
//  - Load_In&Store_In both 1: store performed, Load_Out=0 and rf_Out=0 in DONE.
//  - Inputs ignored outside IDLE (held stable by upstream via Stall_Out).
// TESTING
//  1 Reset: CLR low mid-BUSY -> all outputs 0 next sample, state IDLE, RAM word retains old value.
//  2 Store word 0xDEADBEEF @0x10, then load word @0x10 (WAIT_CYCLES=2) -> Stall high 3 cycles,
//    DONE: Data_Mem_Out=0xDEADBEEF, Load_Out=1, rf_Out=1, Alu_Out=0x10.
//  3 Store byte 0x80 @0x13 on word 0x11223344, load signed byte @0x13 -> 0xFFFFFF80;
//    unsigned -> 0x00000080; load word -> 0x80223344.
//  4 Load half @0x02 with addr[0]=1 (0x03) -> Misalign_Out=1 one cycle, rf_Out=0, no stall beyond 1 cycle.
//  5 ALU op rf_In=1 Alu_In=0x1234 in IDLE -> same cycle rf_Out=1, Alu_Out=0x1234, Stall_Out=0.
//  6 WAIT_CYCLES=0 and address 0x400 with DEPTH_WORDS=256 -> 2-cycle op, aliases word 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage sitting between EX/MEM and MEMWB_Register. Loads and
// stores go to an internal word-organised data RAM that answers after a
// programmable number of wait states. The pipeline is stalled while an access
// is in flight. Non-memory instructions pass straight through in the same
// cycle without stalling.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of 2)
//   WAIT_CYCLES  extra busy cycles per memory op (0..15)
//
// Ports
//   CLK            in   rising-edge clock
//   CLR            in   asynchronous active-low reset
//   Load_In        in   instruction is a load
//   Store_In       in   instruction is a store
//   rf_In          in   instruction writes the register file
//   Size_In        in   00 byte, 01 half, 10/11 word
//   Signed_In      in   1 = sign-extend sub-word loads, 0 = zero-extend
//   Alu_In         in   ALU result / effective address
//   Store_Data_In  in   store data (low byte/half for sub-word stores)
//   Load_Out       out  to MEMWB Load_In
//   rf_Out         out  to MEMWB rf_In
//   Data_Mem_Out   out  extended load data, to MEMWB Data_Mem_In
//   Alu_Out        out  to MEMWB Alu_In
//   Stall_Out      out  1 = hold upstream pipeline registers
//   Misalign_Out   out  one-cycle flag: misaligned access was suppressed
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Load_In,
    input  logic        Store_In,
    input  logic        rf_In,
    input  logic [1:0]  Size_In,
    input  logic        Signed_In,
    input  logic [31:0] Alu_In,
    input  logic [31:0] Store_Data_In,
    output logic        Load_Out,
    output logic        rf_Out,
    output logic [31:0] Data_Mem_Out,
    output logic [31:0] Alu_Out,
    output logic        Stall_Out,
    output logic        Misalign_Out
);

    localparam int ADDR_WIDTH = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter is loaded one below WAIT_CYCLES so that reaching zero marks
    // the last busy cycle; with no wait states BUSY is skipped altogether.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lane[0];
            default: is_misaligned = |lane;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate the sub-word store data into every lane so the byte enables
    // alone pick which lane lands in the RAM.
    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   ext_load = sgn ? 32'(b) : {24'd0, b};
            2'b01:   ext_load = sgn ? 32'(h) : {16'd0, h};
            default: ext_load = w;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State and latched operation
    // -----------------------------------------------------------------------
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        load_p0;
    logic        store_p0;
    logic        rf_p0;
    logic [1:0]  size_p0;
    logic        sgn_p0;
    logic        mis_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] rdata_p1;

    logic [31:0] mem [DEPTH_WORDS];

    logic                  mem_op;
    logic                  mis_in;
    logic                  commit;
    logic                  cur_load;
    logic                  cur_store;
    logic [1:0]            cur_size;
    logic                  cur_sgn;
    logic [1:0]            cur_lane;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic [31:0]           cur_lanes;

    assign mem_op = Load_In | Store_In;
    assign mis_in = is_misaligned(Size_In, Alu_In[1:0]);

    // With zero wait states the RAM access happens on the same edge that
    // leaves IDLE, before the latches hold the operation, so the access
    // fields come straight from the inputs while in IDLE.
    always_comb begin
        if (state == IDLE) begin
            cur_load  = Load_In;
            cur_store = Store_In;
            cur_size  = Size_In;
            cur_sgn   = Signed_In;
            cur_lane  = Alu_In[1:0];
            cur_idx   = Alu_In[ADDR_WIDTH+1:2];
            cur_wdata = Store_Data_In;
        end else begin
            cur_load  = load_p0;
            cur_store = store_p0;
            cur_size  = size_p0;
            cur_sgn   = sgn_p0;
            cur_lane  = addr_p0[1:0];
            cur_idx   = addr_p0[ADDR_WIDTH+1:2];
            cur_wdata = wdata_p0;
        end
    end

    assign cur_be    = byte_en(cur_size, cur_lane);
    assign cur_lanes = lane_data(cur_size, cur_wdata);

    // RAM access fires on the edge that enters DONE. Misaligned ops go
    // IDLE->DONE without ever satisfying this, so they never touch the RAM.
    assign commit = CLR &&
                    (((state == IDLE) && mem_op && !mis_in && (WAIT_CYCLES == 0)) ||
                     ((state == BUSY) && (cnt == 4'd0)));

    // -----------------------------------------------------------------------
    // Stage boundary: RAM write port (contents survive reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (commit && cur_store) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_lanes[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage boundary: control FSM, operation latch and read register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            load_p0  <= 1'b0;
            store_p0 <= 1'b0;
            rf_p0    <= 1'b0;
            size_p0  <= 2'b00;
            sgn_p0   <= 1'b0;
            mis_p0   <= 1'b0;
            addr_p0  <= 32'd0;
            wdata_p0 <= 32'd0;
            rdata_p1 <= 32'd0;
        end else begin
            if (commit) begin
                rdata_p1 <= (cur_load && !cur_store)
                            ? ext_load(mem[cur_idx], cur_size, cur_lane, cur_sgn)
                            : 32'd0;
            end

            case (state)
                IDLE: begin
                    if (mem_op) begin
                        load_p0  <= Load_In;
                        store_p0 <= Store_In;
                        rf_p0    <= rf_In;
                        size_p0  <= Size_In;
                        sgn_p0   <= Signed_In;
                        mis_p0   <= mis_in;
                        addr_p0  <= Alu_In;
                        wdata_p0 <= Store_Data_In;
                        if (mis_in || (WAIT_CYCLES == 0)) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Stage boundary: outputs toward MEMWB_Register
    // -----------------------------------------------------------------------
    always_comb begin
        Load_Out     = 1'b0;
        rf_Out       = 1'b0;
        Data_Mem_Out = 32'd0;
        Alu_Out      = 32'd0;
        Stall_Out    = 1'b0;
        Misalign_Out = 1'b0;
        // Outputs are forced low for as long as reset is asserted, even
        // though IDLE would otherwise pass rf_In/Alu_In through.
        if (CLR) begin
            case (state)
                IDLE: begin
                    Stall_Out = mem_op;
                    rf_Out    = mem_op ? 1'b0 : rf_In;
                    Alu_Out   = Alu_In;
                end
                BUSY: begin
                    Stall_Out = 1'b1;
                    Alu_Out   = addr_p0;
                end
                DONE: begin
                    Alu_Out      = addr_p0;
                    Misalign_Out = mis_p0;
                    if (!mis_p0) begin
                        // A combined load+store behaves as a store only.
                        Load_Out     = load_p0 & ~store_p0;
                        rf_Out       = rf_p0 & ~(load_p0 & store_p0);
                        Data_Mem_Out = rdata_p1;
                    end
                end
                default: begin
                    Stall_Out = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    // Instance with two wait states
    logic        a_ld, a_st, a_rf, a_sg;
    logic [1:0]  a_sz;
    logic [31:0] a_alu, a_sd;
    logic        a_lo, a_rfo, a_stall, a_mis;
    logic [31:0] a_dmo, a_alo;

    // Instance with zero wait states
    logic        z_ld, z_st, z_rf, z_sg;
    logic [1:0]  z_sz;
    logic [31:0] z_alu, z_sd;
    logic        z_lo, z_rfo, z_stall, z_mis;
    logic [31:0] z_dmo, z_alo;

    mem_access_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .CLR(CLR),
        .Load_In(a_ld), .Store_In(a_st), .rf_In(a_rf), .Size_In(a_sz), .Signed_In(a_sg),
        .Alu_In(a_alu), .Store_Data_In(a_sd),
        .Load_Out(a_lo), .rf_Out(a_rfo), .Data_Mem_Out(a_dmo), .Alu_Out(a_alo),
        .Stall_Out(a_stall), .Misalign_Out(a_mis)
    );

    mem_access_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .CLR(CLR),
        .Load_In(z_ld), .Store_In(z_st), .rf_In(z_rf), .Size_In(z_sz), .Signed_In(z_sg),
        .Alu_In(z_alu), .Store_Data_In(z_sd),
        .Load_Out(z_lo), .rf_Out(z_rfo), .Data_Mem_Out(z_dmo), .Alu_Out(z_alo),
        .Stall_Out(z_stall), .Misalign_Out(z_mis)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory images, one per instance
    logic [31:0] m2 [256];
    logic [31:0] m0 [256];

    task automatic idle_inputs();
        a_ld = 0; a_st = 0; a_rf = 0; a_sz = 2'b00; a_sg = 0; a_alu = 0; a_sd = 0;
        z_ld = 0; z_st = 0; z_rf = 0; z_sz = 2'b00; z_sg = 0; z_alu = 0; z_sd = 0;
    endtask

    task automatic drive(input bit w0, input logic ld, st, rf, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, data);
        if (w0) begin
            z_ld = ld; z_st = st; z_rf = rf; z_sz = sz; z_sg = sg; z_alu = addr; z_sd = data;
        end else begin
            a_ld = ld; a_st = st; a_rf = rf; a_sz = sz; a_sg = sg; a_alu = addr; a_sd = data;
        end
    endtask

    // Behavioural model: byte-addressed arithmetic on a word image.
    task automatic model_op(input bit w0, input logic ld, st, rf, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, data,
                            output int e_stall, output logic e_ld, e_rf, e_mis,
                            output logic [31:0] e_data);
        int nb, off, idx;
        logic [31:0] word, val, lim;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        idx = int'((addr / 4) % 256);
        e_mis = ((off % nb) != 0);
        word = w0 ? m0[idx] : m2[idx];
        val = 0;
        if (ld && !st && !e_mis) begin
            val = word >> (8 * off);
            if (nb < 4) begin
                lim = 32'd1 << (8 * nb);
                val = val % lim;
                if (sg && val >= lim / 2) val = val - lim;
            end
        end
        if (st && !e_mis) begin
            for (int k = 0; k < nb; k++) word[8*(off+k) +: 8] = data[8*k +: 8];
            if (w0) m0[idx] = word; else m2[idx] = word;
        end
        e_stall = e_mis ? 1 : (w0 ? 1 : 3);
        e_ld   = ld && !st && !e_mis;
        e_rf   = rf && !(ld && st) && !e_mis;
        e_data = e_ld ? val : 32'd0;
    endtask

    // Issues one op, counts stalled samples and captures the first
    // non-stalled (DONE) cycle plus Misalign_Out one cycle later.
    task automatic do_op(input bit w0, input logic ld, st, rf, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, data,
                         output int nstall, output logic o_ld, o_rf, o_mis, o_mis_after,
                         output logic [31:0] o_data, o_alu);
        bit done;
        @(posedge CLK); #1;
        drive(w0, ld, st, rf, sz, sg, addr, data);
        nstall = 0; done = 0;
        o_ld = 0; o_rf = 0; o_mis = 0; o_data = 0; o_alu = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if ((w0 ? z_stall : a_stall) === 1'b1) nstall++;
            else begin
                done   = 1;
                o_ld   = w0 ? z_lo  : a_lo;
                o_rf   = w0 ? z_rfo : a_rfo;
                o_mis  = w0 ? z_mis : a_mis;
                o_data = w0 ? z_dmo : a_dmo;
                o_alu  = w0 ? z_alo : a_alo;
            end
        end
        if (!done) nstall = -1;
        @(posedge CLK); #1;
        idle_inputs();
        @(negedge CLK);
        o_mis_after = w0 ? z_mis : a_mis;
    endtask

    int          n;
    logic        o_ld, o_rf, o_mis, o_ma;
    logic [31:0] o_data, o_alu;
    int          e_stall;
    logic        e_ld, e_rf, e_mis;
    logic [31:0] e_data;

    task automatic test_reset_idle();
        CLR = 1'b1;
        drive(0, 1, 0, 1, 2'b10, 0, 32'h0000ABCD, 32'h12345678);
        #3 CLR = 1'b0;
        #10;
        checks++;
        if ({a_stall, a_rfo, a_lo, a_mis, a_dmo, a_alo} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b rf=%b ld=%b mis=%b data=%h alu=%h want all 0",
                     a_stall, a_rfo, a_lo, a_mis, a_dmo, a_alo);
        end
        idle_inputs();
        @(negedge CLK) CLR = 1'b1;
    endtask

    task automatic fill_memories();
        logic [31:0] d;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            model_op(0, 0, 1, 0, 2'b10, 0, i * 4, d, e_stall, e_ld, e_rf, e_mis, e_data);
            do_op(0, 0, 1, 0, 2'b10, 0, i * 4, d, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
            d = $urandom;
            model_op(1, 0, 1, 0, 2'b10, 0, i * 4, d, e_stall, e_ld, e_rf, e_mis, e_data);
            do_op(1, 0, 1, 0, 2'b10, 0, i * 4, d, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] old;
        old = m2[8];
        @(posedge CLK); #1;
        drive(0, 0, 1, 0, 2'b10, 0, 32'h20, ~old);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (a_stall !== 1'b1) begin
            errors++; $display("FAIL busy_stall got %b want 1", a_stall);
        end
        #2 CLR = 1'b0;
        #1;
        checks++;
        if ({a_stall, a_rfo, a_lo, a_mis, a_dmo, a_alo} !== 68'd0) begin
            errors++;
            $display("FAIL midop_reset got stall=%b rf=%b ld=%b mis=%b data=%h alu=%h want all 0",
                     a_stall, a_rfo, a_lo, a_mis, a_dmo, a_alo);
        end
        idle_inputs();
        @(negedge CLK) CLR = 1'b1;
        @(posedge CLK); #1;
        drive(0, 0, 0, 1, 2'b00, 0, 32'h55, 0);
        #1;
        checks++;
        if (a_stall !== 1'b0 || a_rfo !== 1'b1 || a_alo !== 32'h55) begin
            errors++;
            $display("FAIL after_reset_idle got stall=%b rf=%b alu=%h want 0 1 00000055",
                     a_stall, a_rfo, a_alo);
        end
        idle_inputs();
        do_op(0, 1, 0, 1, 2'b10, 0, 32'h20, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== old) begin
            errors++; $display("FAIL dropped_store got %h want %h", o_data, old);
        end
    endtask

    task automatic test_store_load_word();
        model_op(0, 0, 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 0, 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL store_stall got %0d want 3", n); end
        model_op(0, 1, 0, 1, 2'b10, 0, 32'h10, 0, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 1, 0, 1, 2'b10, 0, 32'h10, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL load_stall got %0d want 3", n); end
        checks++;
        if (o_data !== 32'hDEADBEEF || o_ld !== 1'b1 || o_rf !== 1'b1 || o_alu !== 32'h10) begin
            errors++;
            $display("FAIL load_word got data=%h ld=%b rf=%b alu=%h want deadbeef 1 1 00000010",
                     o_data, o_ld, o_rf, o_alu);
        end
    endtask

    task automatic test_subword();
        model_op(0, 0, 1, 0, 2'b10, 0, 32'h10, 32'h11223344, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 0, 1, 0, 2'b10, 0, 32'h10, 32'h11223344, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        model_op(0, 0, 1, 0, 2'b00, 0, 32'h13, 32'hA5A5A580, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 0, 1, 0, 2'b00, 0, 32'h13, 32'hA5A5A580, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        do_op(0, 1, 0, 1, 2'b00, 1, 32'h13, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", o_data); end
        do_op(0, 1, 0, 1, 2'b00, 0, 32'h13, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got %h want 00000080", o_data); end
        do_op(0, 1, 0, 1, 2'b10, 0, 32'h10, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'h80223344) begin errors++; $display("FAIL lw_after_sb got %h want 80223344", o_data); end
        model_op(0, 0, 1, 0, 2'b01, 0, 32'h12, 32'h5A5ABEEF, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 0, 1, 0, 2'b01, 0, 32'h12, 32'h5A5ABEEF, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        do_op(0, 1, 0, 1, 2'b01, 1, 32'h12, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_signed got %h want ffffbeef", o_data); end
        do_op(0, 1, 0, 1, 2'b01, 0, 32'h10, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'h00003344) begin errors++; $display("FAIL lh_unsigned got %h want 00003344", o_data); end
    endtask

    task automatic test_misalign();
        do_op(0, 1, 0, 1, 2'b01, 0, 32'h03, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL misalign_stall got %0d want 1", n); end
        checks++;
        if (o_mis !== 1'b1 || o_rf !== 1'b0 || o_ld !== 1'b0 || o_data !== 32'd0) begin
            errors++;
            $display("FAIL misalign_done got mis=%b rf=%b ld=%b data=%h want 1 0 0 0",
                     o_mis, o_rf, o_ld, o_data);
        end
        checks++;
        if (o_ma !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b want 0", o_ma); end
        model_op(0, 0, 1, 1, 2'b10, 0, 32'h11, 32'h0BADF00D, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 0, 1, 1, 2'b10, 0, 32'h11, 32'h0BADF00D, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        do_op(0, 1, 0, 1, 2'b10, 0, 32'h10, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'hBEEF3344) begin errors++; $display("FAIL misaligned_store_suppressed got %h want beef3344", o_data); end
    endtask

    task automatic test_alu_pass();
        @(posedge CLK); #1;
        drive(0, 0, 0, 1, 2'b00, 0, 32'h1234, 0);
        #1;
        checks++;
        if (a_rfo !== 1'b1 || a_alo !== 32'h1234 || a_stall !== 1'b0 || a_lo !== 1'b0 || a_dmo !== 32'd0) begin
            errors++;
            $display("FAIL alu_pass got rf=%b alu=%h stall=%b ld=%b data=%h want 1 00001234 0 0 0",
                     a_rfo, a_alo, a_stall, a_lo, a_dmo);
        end
        a_alu = 32'h5678;
        #1;
        checks++;
        if (a_alo !== 32'h5678) begin errors++; $display("FAIL alu_pass_follow got %h want 00005678", a_alo); end
        idle_inputs();
    endtask

    task automatic test_wait0_alias();
        model_op(1, 0, 1, 0, 2'b10, 0, 32'h400, 32'hCAFEF00D, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(1, 0, 1, 0, 2'b10, 0, 32'h400, 32'hCAFEF00D, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL wait0_store_stall got %0d want 1", n); end
        do_op(1, 1, 0, 1, 2'b10, 0, 32'h0, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (n !== 1 || o_data !== 32'hCAFEF00D || o_ld !== 1'b1) begin
            errors++;
            $display("FAIL wait0_alias got stall=%0d data=%h ld=%b want 1 cafef00d 1", n, o_data, o_ld);
        end
    endtask

    task automatic test_load_store_both();
        model_op(0, 1, 1, 1, 2'b10, 0, 32'h40, 32'h600DCAFE, e_stall, e_ld, e_rf, e_mis, e_data);
        do_op(0, 1, 1, 1, 2'b10, 0, 32'h40, 32'h600DCAFE, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_ld !== 1'b0 || o_rf !== 1'b0 || o_data !== 32'd0) begin
            errors++;
            $display("FAIL both_done got ld=%b rf=%b data=%h want 0 0 0", o_ld, o_rf, o_data);
        end
        do_op(0, 1, 0, 1, 2'b10, 0, 32'h40, 0, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
        checks++;
        if (o_data !== 32'h600DCAFE) begin errors++; $display("FAIL both_stored got %h want 600dcafe", o_data); end
    endtask

    task automatic test_random();
        bit          w0;
        logic        ld, st, rf, sg;
        logic [1:0]  sz;
        logic [31:0] addr, data;
        int          kind;
        for (int i = 0; i < 120; i++) begin
            w0   = ($urandom_range(0, 3) == 0);
            kind = $urandom_range(0, 4);
            ld   = (kind != 1);
            st   = (kind == 1) || (kind == 2);
            rf   = $urandom_range(0, 1);
            sg   = $urandom_range(0, 1);
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 32'h1FFF));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) addr[0] = 1'b0;
                if (sz[1]) addr[1:0] = 2'b00;
            end
            data = $urandom;
            model_op(w0, ld, st, rf, sz, sg, addr, data, e_stall, e_ld, e_rf, e_mis, e_data);
            do_op(w0, ld, st, rf, sz, sg, addr, data, n, o_ld, o_rf, o_mis, o_ma, o_data, o_alu);
            checks++;
            if (n !== e_stall) begin errors++; $display("FAIL rnd%0d_stall got %0d want %0d", i, n, e_stall); end
            checks++;
            if (o_data !== e_data) begin errors++; $display("FAIL rnd%0d_data got %h want %h", i, o_data, e_data); end
            checks++;
            if ({o_ld, o_rf, o_mis, o_ma} !== {e_ld, e_rf, e_mis, 1'b0}) begin
                errors++;
                $display("FAIL rnd%0d_flags got ld/rf/mis/mis_next=%b%b%b%b want %b%b%b0",
                         i, o_ld, o_rf, o_mis, o_ma, e_ld, e_rf, e_mis);
            end
            checks++;
            if (o_alu !== addr) begin errors++; $display("FAIL rnd%0d_alu got %h want %h", i, o_alu, addr); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset_idle();
        fill_memories();
        test_reset_mid_busy();
        test_store_load_word();
        test_subword();
        test_misalign();
        test_alu_pass();
        test_wait0_alias();
        test_load_store_both();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
